// File: rtl/num_ctrl.sv
`default_nettype none
// num_ctrl: sequences the NUM instruction -- hands rA/rX bytes to the
// character-to-number converter and writes the signed result back as rA.
module num_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [30:0] ra_in,
  input  logic [29:0] rx_in,
  output logic        busy,
  output logic        cv_start,
  output logic [59:0] cv_in,
  input  logic [29:0] cv_out,
  input  logic        cv_stop,
  output logic [30:0] ra_out,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [59:0] cv_in_q, cv_in_d;
  logic [30:0] ra_q, ra_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      cv_in_q <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      cv_in_q <= cv_in_d;
      ra_q    <= ra_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    cv_in_d = cv_in_q;
    ra_d    = ra_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          sign_d  = ra_in[30];
          cv_in_d = {ra_in[29:0], rx_in};
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A strobe in the final wait cycle still wins over the timeout.
        if (cv_stop) begin
          ra_d    = {sign_q, cv_out};
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign cv_start = (state_q == START);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign cv_in    = cv_in_q;
  assign ra_out   = ra_q;

endmodule
`default_nettype wire

// File: tb/tb_num_ctrl.sv
`timescale 1ns/1ps
module tb_num_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [30:0] ra_in = '0;
  logic [29:0] rx_in = '0;
  logic        busy, cv_start, cv_stop, done, err;
  logic [59:0] cv_in;
  logic [29:0] cv_out;
  logic [30:0] ra_out;

  logic        stub_stop = 1'b0, stale_stop = 1'b0;
  logic [29:0] stub_out = '0, stale_out = '0;
  assign cv_stop = stub_stop | stale_stop;
  assign cv_out  = stale_stop ? stale_out : stub_out;

  num_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ra_in(ra_in), .rx_in(rx_in),
    .busy(busy), .cv_start(cv_start), .cv_in(cv_in), .cv_out(cv_out),
    .cv_stop(cv_stop), .ra_out(ra_out), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { bit ok; logic [30:0] ra; int at; } exp_t;
  typedef struct { int at; logic [59:0] opnd; } st_t;
  exp_t sbq[$];
  st_t  stq[$];
  int   kq[$];
  int   next_free = 0, last_acc = -1;
  logic [30:0] exp_ra = '0;

  // Character-to-number rule: each byte contributes (byte mod 10) as one
  // decimal digit, most significant first; result taken modulo 2^30.
  function automatic logic [29:0] num_of(input logic [59:0] b);
    longint v = 0;
    for (int i = 9; i >= 0; i--) v = v * 10 + longint'(b[i*6 +: 6] % 6'd10);
    return v[29:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Converter model: answers k cycles after the start pulse (k=0: never).
  initial begin
    int k = 0, st = 0;
    bit pend = 0;
    logic [29:0] val = '0;
    forever begin
      @(negedge clk);
      stub_stop = 1'b0;
      if (pend && cyc == st + k) begin
        stub_stop = 1'b1;
        stub_out  = val;
        pend      = 0;
      end
      if (cv_start && rst_n) begin
        k = (kq.size() != 0) ? kq.pop_front() : 0;
        if (k > 0) begin
          pend = 1;
          st   = cyc;
          val  = num_of(cv_in);
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start or outcome.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_ra = '0;
      end else begin
        if (cv_start) begin
          if (stq.size() == 0) begin
            checks++; errors++;
            $display("FAIL cv_start: unexpected pulse got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            st_t s;
            s = stq.pop_front();
            chk("cv_start_cycle", 64'(cyc), 64'(s.at));
            chk("cv_in", 64'(cv_in), 64'(s.opnd));
          end
        end
        if (done || err) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL outcome: unexpected done=%0b err=%0b expected none (cycle %0d)", done, err, cyc);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("outcome_cycle", 64'(cyc), 64'(e.at));
            chk("done", 64'(done), 64'(e.ok));
            chk("err", 64'(err), 64'(!e.ok));
            if (e.ok) exp_ra = e.ra;
          end
        end
        chk("ra_out", 64'(ra_out), 64'(exp_ra));
      end
    end
  end

  task automatic step(input bit r, input int k, input logic [30:0] a, input logic [29:0] x,
                      input bit stale, input bit rel);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    chk("busy", 64'(busy), 64'(cyc > last_acc && cyc < next_free));
    req       = r;
    ra_in     = a;
    rx_in     = x;
    stale_stop = stale && !r && (cyc >= next_free);
    stale_out  = 30'($urandom);
    if (r && cyc >= next_free) begin
      last_acc = cyc;
      stq.push_back('{cyc + 1, {a[29:0], x}});
      kq.push_back(k);
      if (k >= 1 && k <= TO) begin
        sbq.push_back('{1'b1, {a[30], num_of({a[29:0], x})}, cyc + k + 2});
        next_free = cyc + k + 3;
      end else begin
        sbq.push_back('{1'b0, 31'd0, cyc + TO + 2});
        next_free = cyc + TO + 3;
      end
    end
  endtask

  task automatic idle_step(input bit stale);
    step(1'b0, 0, 31'($urandom), 30'($urandom), stale, 1'b0);
  endtask

  task automatic drain();
    while (cyc + 1 < next_free) idle_step(1'b0);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    req = 1'b0;
    stale_stop = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cv_start", 64'(cv_start), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ra_out", 64'(ra_out), 64'd0);
    chk("rst_cv_in", 64'(cv_in), 64'd0);
    sbq.delete(); stq.delete(); kq.delete();
    next_free = 0;
    last_acc  = -1;
    @(negedge clk);
  endtask

  initial begin
    logic [30:0] ones30;
    repeat (2) @(negedge clk);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_cv_start", 64'(cv_start), 64'd0);
    chk("init_done", 64'(done), 64'd0);
    chk("init_err", 64'(err), 64'd0);
    chk("init_ra_out", 64'(ra_out), 64'd0);
    chk("init_cv_in", 64'(cv_in), 64'd0);

    // Basic conversion, accepted on the first edge after reset release.
    step(1'b1, 9, {1'b0, 6'd0, 6'd0, 6'd31, 6'd32, 6'd39}, {5{6'd30}}, 1'b0, 1'b1);
    drain();
    chk("basic_value", 64'(ra_out), 64'({1'b0, 30'd12900000}));
    repeat (3) idle_step(1'b1);

    // Minus zero.
    step(1'b1, 9, {1'b1, {5{6'd30}}}, {5{6'd30}}, 1'b0, 1'b0);
    drain();
    chk("minus_zero", 64'(ra_out), 64'({1'b1, 30'd0}));

    // Timeout: converter never answers, ra_out keeps the minus zero.
    step(1'b1, 0, 31'($urandom), 30'($urandom), 1'b0, 1'b0);
    drain();
    chk("timeout_hold", 64'(ra_out), 64'({1'b1, 30'd0}));
    idle_step(1'b0);

    // Strobe in the last wait cycle, with a magnitude that wraps modulo 2^30.
    ones30 = {1'b0, {5{6'd39}}};
    step(1'b1, 15, ones30, {5{6'd39}}, 1'b0, 1'b0);
    drain();
    chk("race_value", 64'(ra_out), 64'({1'b0, 30'd336323583}));
    idle_step(1'b0);

    // Back-to-back with req held high; requests while busy are ignored.
    repeat (24) step(1'b1, 9, 31'($urandom), 30'($urandom), 1'b0, 1'b0);
    drain();
    idle_step(1'b0);

    // Reset during WAIT; the orphaned converter strobe must be ignored.
    step(1'b1, 9, 31'($urandom), 30'($urandom), 1'b0, 1'b0);
    repeat (5) idle_step(1'b0);
    do_reset();
    step(1'b0, 0, 31'($urandom), 30'($urandom), 1'b0, 1'b1);
    repeat (6) idle_step(1'b0);
    chk("reset_orphan", 64'(ra_out), 64'd0);

    // Randomized traffic: mixed latencies, timeouts, late and stale strobes.
    for (int i = 0; i < 600; i++) begin
      int sel, k;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       k = 9;
      else if (sel < 8)  k = int'($urandom_range(1, 15));
      else if (sel == 8) k = int'($urandom_range(16, 17));
      else               k = 0;
      step($urandom_range(0, 2) != 0, k, 31'($urandom), 30'($urandom),
           $urandom_range(0, 3) == 0, 1'b0);
    end
    drain();
    repeat (3) idle_step(1'b0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("start_q_empty", 64'(stq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
